pll_lock_supervisor: RTL and testbench

Supervises the PLL lock/reset handshake from the consumer side: drives the PLL's active-high reset, watches its `locked` output, and releases the downstream system reset only after lock has been continuously stable. Sits next to the PLL wrapper on the free-running 25 MHz board reference clock, not on any PLL output. Re-arms the PLL on lock loss, lock timeout, or a software relock request, and keeps saturating event counters for the slow-control status registers.

---
 rtl/pll_sup_pkg.sv | 39 +++
 rtl/sync_2ff.sv | 33 +++
 rtl/pll_lock_supervisor.sv | 182 ++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor.
//   pll_state_e : 2-bit FSM state encoding, also exported on state_o
//   Def*        : default parameter values (25 MHz reference clock)
//   clog2/max3  : helpers that size the shared down-counter
package pll_sup_pkg;

    typedef enum logic [1:0] {
        StResetPll = 2'd0,
        StWaitLock = 2'd1,
        StStable   = 2'd2,
        StRun      = 2'd3
    } pll_state_e;

    localparam int unsigned DefRstCycles    = 16;
    localparam int unsigned DefLockTimeout  = 25000;  // 1 ms
    localparam int unsigned DefStableCycles = 2500;   // 100 us
    localparam int unsigned DefGlitchCycles = 4;
    localparam int unsigned DefCntW         = 8;

    // Smallest n with 2**n >= value.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser.
//   refclk : destination clock
//   rst    : synchronous active-low reset, clears both stages
//   d_i    : asynchronous input
//   q_o    : synchronised output, two refclk cycles behind d_i
module sync_2ff (
    input  logic refclk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge refclk) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock/reset supervisor on the free-running reference clock.
// Drives the PLL reset, waits for a continuously stable lock and only then releases
// the downstream reset. Re-arms the PLL on lock loss, lock timeout or relock_req.
//   refclk     : reference clock (the only clock)
//   rst        : synchronous active-low reset
//   pll_locked : PLL locked flag, asynchronous
//   relock_req : single-cycle request to fully re-arm the PLL
//   pll_rst    : active-high PLL reset
//   sys_rst_n  : active-low downstream reset, released only in RUN
//   lock_ok    : high in RUN
//   state_o    : current state (pll_state_e encoding)
//   lost_cnt   : saturating count of lock losses seen in RUN
//   retry_cnt  : saturating count of lock timeouts
// Build option: define PLL_SUP_GLITCH_FILTER_EN to require GLITCH_CYCLES consecutive
// unlocked cycles in RUN before declaring a loss; otherwise one cycle is enough.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = DefRstCycles,
    parameter int unsigned LOCK_TIMEOUT  = DefLockTimeout,
    parameter int unsigned STABLE_CYCLES = DefStableCycles,
    parameter int unsigned GLITCH_CYCLES = DefGlitchCycles,
    parameter int unsigned CNT_W         = DefCntW
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             relock_req,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             lock_ok,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] lost_cnt,
    output logic [CNT_W-1:0] retry_cnt
);

    localparam int unsigned TmrW =
        clog2(max3(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES), GLITCH_CYCLES, 1)) + 1;

    localparam logic [TmrW-1:0] RstLoad    = TmrW'(RST_CYCLES - 1);
    localparam logic [TmrW-1:0] LockLoad   = TmrW'(LOCK_TIMEOUT - 1);
    localparam logic [TmrW-1:0] StableLoad = TmrW'(STABLE_CYCLES - 1);

    pll_state_e       state_q, state_d;
    logic [TmrW-1:0]  tmr_q, tmr_d;
    logic [CNT_W-1:0] lost_cnt_q, lost_cnt_d;
    logic [CNT_W-1:0] retry_cnt_q, retry_cnt_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_n_q, sys_rst_n_d;
    logic             lock_ok_q, lock_ok_d;
    logic             lk;
    logic             lock_lost;

    sync_2ff u_sync_locked (
        .refclk (refclk),
        .rst    (rst),
        .d_i    (pll_locked),
        .q_o    (lk)
    );

`ifdef PLL_SUP_GLITCH_FILTER_EN
    localparam int unsigned GlW = clog2(GLITCH_CYCLES + 1);

    logic [GlW-1:0] glitch_q, glitch_d;

    // Run length of unlocked cycles in RUN; the GLITCH_CYCLES-th one is the loss.
    always_comb begin
        glitch_d  = '0;
        lock_lost = 1'b0;
        if (state_q == StRun && !lk) begin
            if (glitch_q == GlW'(GLITCH_CYCLES - 1)) begin
                lock_lost = 1'b1;
            end else begin
                glitch_d = glitch_q + 1'b1;
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end
`else
    assign lock_lost = (state_q == StRun) && !lk;
`endif

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        lost_cnt_d  = lost_cnt_q;
        retry_cnt_d = retry_cnt_q;

        case (state_q)
            StResetPll: begin
                if (tmr_q == '0) begin
                    state_d = StWaitLock;
                    tmr_d   = LockLoad;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            StWaitLock: begin
                if (lk) begin
                    state_d = StStable;
                    tmr_d   = StableLoad;
                end else if (tmr_q == '0) begin
                    state_d     = StResetPll;
                    tmr_d       = RstLoad;
                    retry_cnt_d = (retry_cnt_q == '1) ? retry_cnt_q : retry_cnt_q + 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            StStable: begin
                // Lock dropped before the window closed: wait again, PLL left alone.
                if (!lk) begin
                    state_d = StWaitLock;
                    tmr_d   = LockLoad;
                end else if (tmr_q == '0) begin
                    state_d = StRun;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            StRun: begin
                if (lock_lost) begin
                    state_d    = StResetPll;
                    tmr_d      = RstLoad;
                    lost_cnt_d = (lost_cnt_q == '1) ? lost_cnt_q : lost_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StResetPll;
                tmr_d   = RstLoad;
            end
        endcase

        // Software relock overrides any same-cycle loss/timeout and is not counted.
        if (relock_req && state_q != StResetPll) begin
            state_d     = StResetPll;
            tmr_d       = RstLoad;
            lost_cnt_d  = lost_cnt_q;
            retry_cnt_d = retry_cnt_q;
        end

        // Outputs follow the next state so they change on the same edge as state_q.
        pll_rst_d   = (state_d == StResetPll);
        sys_rst_n_d = (state_d == StRun);
        lock_ok_d   = (state_d == StRun);
    end

    always_ff @(posedge refclk) begin
        if (!rst) begin
            state_q     <= StResetPll;
            tmr_q       <= RstLoad;
            lost_cnt_q  <= '0;
            retry_cnt_q <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            lock_ok_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            lost_cnt_q  <= lost_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            lock_ok_q   <= lock_ok_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign lock_ok   = lock_ok_q;
    assign state_o   = state_q;
    assign lost_cnt  = lost_cnt_q;
    assign retry_cnt = retry_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small timing parameters.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_pll_lock_supervisor;

    localparam int unsigned RstCycles    = 4;
    localparam int unsigned LockTimeout  = 20;
    localparam int unsigned StableCycles = 10;
    localparam int unsigned GlitchCycles = 3;
    localparam int unsigned CntW         = 2;

    localparam logic [1:0] SReset  = 2'd0;
    localparam logic [1:0] SWait   = 2'd1;
    localparam logic [1:0] SStable = 2'd2;
    localparam logic [1:0] SRun    = 2'd3;

    // {pll_rst, sys_rst_n, lock_ok, state_o, lost_cnt, retry_cnt}
    localparam logic [8:0] ResetVec = 9'b1_0_0_00_00_00;

    logic            refclk = 1'b0;
    logic            rst = 1'b0;
    logic            pll_locked = 1'b0;
    logic            relock_req = 1'b0;
    logic            pll_rst;
    logic            sys_rst_n;
    logic            lock_ok;
    logic [1:0]      state_o;
    logic [CntW-1:0] lost_cnt;
    logic [CntW-1:0] retry_cnt;

    int n_tests = 0;
    int n_fail = 0;

    // pll_rst pulse length monitor, counted in whole cycles at the falling edge.
    int pulse_len = 0;
    int last_pulse = 0;
    int pulse_count = 0;

    always #20 refclk = ~refclk;

    pll_lock_supervisor #(
        .RST_CYCLES    (RstCycles),
        .LOCK_TIMEOUT  (LockTimeout),
        .STABLE_CYCLES (StableCycles),
        .GLITCH_CYCLES (GlitchCycles),
        .CNT_W         (CntW)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .lock_ok    (lock_ok),
        .state_o    (state_o),
        .lost_cnt   (lost_cnt),
        .retry_cnt  (retry_cnt)
    );

    always @(negedge refclk) begin
        if (!rst) begin
            pulse_len = 0;
        end else if (pll_rst) begin
            pulse_len = pulse_len + 1;
        end else if (pulse_len != 0) begin
            last_pulse  = pulse_len;
            pulse_count = pulse_count + 1;
            pulse_len   = 0;
        end
    end

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] st, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= max_cyc; i++) begin
            if (state_o == st) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        pll_locked = 1'b0;
        repeat (3) step();
        n_tests++;
        if ({pll_rst, sys_rst_n, lock_ok, state_o, lost_cnt, retry_cnt} !== ResetVec) begin
            n_fail++;
            $display("FAIL reset_values: got %b want %b",
                     {pll_rst, sys_rst_n, lock_ok, state_o, lost_cnt, retry_cnt}, ResetVec);
        end
    endtask

    task automatic test_bring_up();
        bit ok;
        int n;
        rst = 1'b1;
        wait_state(SWait, 10, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bringup_wait_lock: state %0d, want %0d", state_o, SWait);
        end
        repeat (3) step();
        n_tests++;
        if (pulse_count !== 1 || last_pulse !== 4) begin
            n_fail++;
            $display("FAIL bringup_pll_rst_pulse: count %0d len %0d, want 1 pulse of 4",
                     pulse_count, last_pulse);
        end
        // Cycle in which pll_locked rises is cycle 1; sys_rst_n rises in cycle 2+1+10+1.
        pll_locked = 1'b1;
        n = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            n++;
            if (sys_rst_n) break;
        end
        n_tests++;
        if (n !== 14) begin
            n_fail++;
            $display("FAIL bringup_latency: sys_rst_n rose in cycle %0d, want 14", n);
        end
        n_tests++;
        if (state_o !== SRun || lock_ok !== 1'b1 || pll_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL bringup_run: state %0d lock_ok %b pll_rst %b, want 3 1 0",
                     state_o, lock_ok, pll_rst);
        end
        n_tests++;
        if (lost_cnt !== 2'd0 || retry_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL bringup_counters: lost %0d retry %0d, want 0 0", lost_cnt, retry_cnt);
        end
    endtask

    task automatic test_loss_in_run();
        bit ok;
        bit stayed;
`ifdef PLL_SUP_GLITCH_FILTER_EN
        // Two-cycle dropout is shorter than the filter and must be ignored.
        pll_locked = 1'b0;
        repeat (2) step();
        pll_locked = 1'b1;
        stayed = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (state_o !== SRun || sys_rst_n !== 1'b1) stayed = 1'b0;
        end
        n_tests++;
        if (!stayed || lost_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL glitch_short_ignored: stayed %b lost %0d, want 1 0", stayed, lost_cnt);
        end
        pll_locked = 1'b0;
        repeat (3) step();
        pll_locked = 1'b1;
`else
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
`endif
        stayed = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (state_o !== SRun) begin
                stayed = 1'b0;
                break;
            end
            step();
        end
        n_tests++;
        if (stayed) begin
            n_fail++;
            $display("FAIL loss_exit: state %0d still RUN, want exit", state_o);
        end
        n_tests++;
        if (state_o !== SReset || sys_rst_n !== 1'b0 || pll_rst !== 1'b1 || lock_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL loss_same_cycle: state %0d sys_rst_n %b pll_rst %b lock_ok %b, want 0 0 1 0",
                     state_o, sys_rst_n, pll_rst, lock_ok);
        end
        n_tests++;
        if (lost_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL loss_count: lost %0d, want 1", lost_cnt);
        end
        wait_state(SWait, 10, ok);
        step();
        n_tests++;
        if (!ok || last_pulse !== 4) begin
            n_fail++;
            $display("FAIL loss_pll_rst_pulse: reached %b len %0d, want 1 4", ok, last_pulse);
        end
    endtask

    task automatic test_chatter_in_stable();
        bit ok;
        bit saw_wait;
        bit saw_rst;
        int stable_n;
        int pulses0;
        wait_state(SStable, 20, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL chatter_reach_stable: state %0d, want %0d", state_o, SStable);
        end
        repeat (4) step();
        pulses0 = pulse_count;
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        saw_wait = 1'b0;
        saw_rst = 1'b0;
        stable_n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (state_o == SWait) saw_wait = 1'b1;
            if (pll_rst) saw_rst = 1'b1;
            if (saw_wait && state_o == SStable) stable_n++;
            if (state_o == SRun) break;
        end
        n_tests++;
        if (saw_wait !== 1'b1) begin
            n_fail++;
            $display("FAIL chatter_back_to_wait: saw WAIT %b, want 1", saw_wait);
        end
        n_tests++;
        if (saw_rst !== 1'b0 || pulse_count !== pulses0) begin
            n_fail++;
            $display("FAIL chatter_no_pll_rst: pll_rst seen %b pulses %0d, want 0 %0d",
                     saw_rst, pulse_count, pulses0);
        end
        n_tests++;
        if (stable_n !== 10 || state_o !== SRun) begin
            n_fail++;
            $display("FAIL chatter_window_restart: stable %0d state %0d, want 10 3",
                     stable_n, state_o);
        end
    endtask

    task automatic test_relock_with_loss();
        pll_locked = 1'b0;
        // Line up relock_req with the edge on which the loss would be declared.
`ifdef PLL_SUP_GLITCH_FILTER_EN
        repeat (4) step();
`else
        repeat (2) step();
`endif
        n_tests++;
        if (state_o !== SRun) begin
            n_fail++;
            $display("FAIL relock_precondition: state %0d, want 3", state_o);
        end
        relock_req = 1'b1;
        step();
        relock_req = 1'b0;
        n_tests++;
        if (state_o !== SReset || pll_rst !== 1'b1 || sys_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL relock_next_cycle: state %0d pll_rst %b sys_rst_n %b, want 0 1 0",
                     state_o, pll_rst, sys_rst_n);
        end
        repeat (3) step();
        n_tests++;
        if (lost_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL relock_lost_unchanged: lost %0d, want 1", lost_cnt);
        end
    endtask

    task automatic test_no_lock();
        bit ok;
        int n;
        logic [CntW-1:0] exp_retry;
        for (int k = 1; k <= 4; k++) begin
            exp_retry = (k < 3) ? CntW'(k) : 2'd3;
            wait_state(SWait, 10, ok);
            n = 0;
            for (int i = 0; i < 40; i++) begin
                if (state_o != SWait) break;
                n++;
                step();
            end
            n_tests++;
            if (!ok || n !== 20) begin
                n_fail++;
                $display("FAIL nolock_timeout_%0d: reached %b wait cycles %0d, want 1 20", k, ok, n);
            end
            n_tests++;
            if (state_o !== SReset || pll_rst !== 1'b1) begin
                n_fail++;
                $display("FAIL nolock_rearm_%0d: state %0d pll_rst %b, want 0 1", k, state_o, pll_rst);
            end
            n_tests++;
            if (retry_cnt !== exp_retry) begin
                n_fail++;
                $display("FAIL nolock_retry_cnt_%0d: got %0d want %0d", k, retry_cnt, exp_retry);
            end
            n_tests++;
            if (last_pulse !== 4) begin
                n_fail++;
                $display("FAIL nolock_pulse_len_%0d: got %0d want 4", k, last_pulse);
            end
        end
    endtask

    task automatic test_rst_mid_wait();
        bit ok;
        wait_state(SWait, 10, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rstmid_precondition: state %0d, want 1", state_o);
        end
        rst = 1'b0;
        step();
        n_tests++;
        if ({pll_rst, sys_rst_n, lock_ok, state_o, lost_cnt, retry_cnt} !== ResetVec) begin
            n_fail++;
            $display("FAIL rstmid_values: got %b want %b",
                     {pll_rst, sys_rst_n, lock_ok, state_o, lost_cnt, retry_cnt}, ResetVec);
        end
        rst = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_bring_up();
        test_loss_in_run();
        test_chatter_in_stable();
        test_relock_with_loss();
        test_no_lock();
        test_rst_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
